// File: rtl/seq_lut_pkg.sv
// Shared definitions for the sequencer LUT loader.
//   LUT_AW_DFLT / LUT_DW_DFLT : default LUT address / entry widths
//   LUT_DEPTH                 : number of LUT entries
//   seq_lut_state_t           : loader FSM states
//   seq_lut_chk_next()        : one rotate-left-by-one then XOR checksum step
package seq_lut_pkg;

  localparam int unsigned LUT_AW_DFLT = 8;
  localparam int unsigned LUT_DW_DFLT = 32;
  localparam int unsigned LUT_DEPTH   = 256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_CMP  = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } seq_lut_state_t;

  function automatic logic [LUT_DW_DFLT-1:0] seq_lut_chk_next(
    input logic [LUT_DW_DFLT-1:0] chk,
    input logic [LUT_DW_DFLT-1:0] data
  );
    return {chk[LUT_DW_DFLT-2:0], chk[LUT_DW_DFLT-1]} ^ data;
  endfunction

endpackage

// File: rtl/seq_lut_checksum.sv
// Running rotate-XOR checksum register.
//   clk_20mhz, rst_n_20mhz : clock, async active-low reset
//   clr                    : synchronous clear to zero (wins over en)
//   en                     : fold data into the checksum this cycle
//   data                   : word to fold
//   chk                    : current checksum
module seq_lut_checksum
  import seq_lut_pkg::*;
#(
  parameter int unsigned DW = LUT_DW_DFLT
) (
  input  logic          clk_20mhz,
  input  logic          rst_n_20mhz,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] chk
);

  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      chk <= '0;
    end else if (clr) begin
      chk <= '0;
    end else if (en) begin
      chk <= seq_lut_chk_next(chk, data);
    end
  end

endmodule

// File: rtl/seq_lut_loader.sv
// Host-side loader for the sequencer LUT: accepts a valid/ready burst of
// entries, writes them to consecutive (wrapping) LUT addresses, then raises
// config_done_o. With SEQ_LUT_VERIFY_EN defined the table is read back and
// its checksum compared with the checksum of the written data.
//   clk_20mhz, rst_n_20mhz        : clock, async active-low reset
//   load_start_i, base_addr_i,
//   entry_count_i                 : start pulse, first address, entry count
//   abort_i, seq_busy_i           : abandon load / sequencer busy
//   s_data_i, s_valid_i, s_ready_o: entry stream
//   lut_addr_o, lut_wen_o,
//   lut_write_data_o,
//   lut_read_data_i               : LUT port (read data one cycle after addr)
//   config_done_o, busy_o,
//   load_error_o,
//   entries_written_o             : status
// The checksum helper is fixed at the package default entry width.
module seq_lut_loader
  import seq_lut_pkg::*;
#(
  parameter int unsigned LUT_AW = LUT_AW_DFLT,
  parameter int unsigned LUT_DW = LUT_DW_DFLT
) (
  input  logic              clk_20mhz,
  input  logic              rst_n_20mhz,
  input  logic              load_start_i,
  input  logic [LUT_AW-1:0] base_addr_i,
  input  logic [LUT_AW:0]   entry_count_i,
  input  logic              abort_i,
  input  logic              seq_busy_i,
  input  logic [LUT_DW-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [LUT_AW-1:0] lut_addr_o,
  output logic              lut_wen_o,
  output logic [LUT_DW-1:0] lut_write_data_o,
  input  logic [LUT_DW-1:0] lut_read_data_i,
  output logic              config_done_o,
  output logic              busy_o,
  output logic              load_error_o,
  output logic [LUT_AW:0]   entries_written_o
);

  localparam int unsigned CW = LUT_AW + 1;

  seq_lut_state_t    state_q, state_d;
  logic [CW-1:0]     left_q, left_d;
  logic [LUT_AW-1:0] ptr_q, ptr_d;
  logic              s_ready_q, s_ready_d;
  logic              lut_wen_q, lut_wen_d;
  logic [LUT_AW-1:0] lut_addr_q, lut_addr_d;
  logic [LUT_DW-1:0] lut_wdata_q, lut_wdata_d;
  logic              config_done_q, config_done_d;
  logic              busy_q, busy_d;
  logic              load_error_q, load_error_d;
  logic [CW-1:0]     entries_q, entries_d;

  logic              hs_c;
  logic              abort_c;
  logic              chk_clr_c;
  logic              wr_chk_en_c;
  logic [LUT_DW-1:0] wr_chk;

  assign hs_c = s_valid_i & s_ready_q;

  // A sequencer going busy mid-load is handled exactly like an abort.
  assign abort_c = abort_i |
                   (seq_busy_i & (state_q inside {ST_WRITE, ST_RD_ADDR, ST_RD_CMP}));

`ifdef SEQ_LUT_VERIFY_EN
  logic [LUT_AW-1:0] base_q, base_d;
  logic [CW-1:0]     count_q, count_d;
  logic              rd_valid_q;
  logic [LUT_DW-1:0] rd_chk;
  logic [LUT_DW-1:0] rd_chk_nxt_c;

  // Final read-side checksum including the word arriving this cycle, so the
  // compare does not wait for the register update.
  assign rd_chk_nxt_c = seq_lut_chk_next(rd_chk, lut_read_data_i);

  seq_lut_checksum #(.DW(LUT_DW)) u_rd_chk (
    .clk_20mhz   (clk_20mhz),
    .rst_n_20mhz (rst_n_20mhz),
    .clr         (chk_clr_c),
    .en          (rd_valid_q),
    .data        (lut_read_data_i),
    .chk         (rd_chk)
  );

  // Read data is valid the cycle after an address was issued in RD_ADDR.
  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      base_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      base_q     <= base_d;
      count_q    <= count_d;
      rd_valid_q <= (state_q == ST_RD_ADDR);
    end
  end
`else
  logic unused_rd_data;
  assign unused_rd_data = ^lut_read_data_i;
`endif

  seq_lut_checksum #(.DW(LUT_DW)) u_wr_chk (
    .clk_20mhz   (clk_20mhz),
    .rst_n_20mhz (rst_n_20mhz),
    .clr         (chk_clr_c),
    .en          (wr_chk_en_c),
    .data        (s_data_i),
    .chk         (wr_chk)
  );

  // State and registered outputs.
  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      state_q       <= ST_IDLE;
      left_q        <= '0;
      ptr_q         <= '0;
      s_ready_q     <= 1'b0;
      lut_wen_q     <= 1'b0;
      lut_addr_q    <= '0;
      lut_wdata_q   <= '0;
      config_done_q <= 1'b0;
      busy_q        <= 1'b0;
      load_error_q  <= 1'b0;
      entries_q     <= '0;
    end else begin
      state_q       <= state_d;
      left_q        <= left_d;
      ptr_q         <= ptr_d;
      s_ready_q     <= s_ready_d;
      lut_wen_q     <= lut_wen_d;
      lut_addr_q    <= lut_addr_d;
      lut_wdata_q   <= lut_wdata_d;
      config_done_q <= config_done_d;
      busy_q        <= busy_d;
      load_error_q  <= load_error_d;
      entries_q     <= entries_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    left_d        = left_q;
    ptr_d         = ptr_q;
    s_ready_d     = 1'b0;
    lut_wen_d     = 1'b0;
    lut_addr_d    = lut_addr_q;
    lut_wdata_d   = lut_wdata_q;
    config_done_d = config_done_q;
    load_error_d  = load_error_q;
    entries_d     = entries_q;
    chk_clr_c     = 1'b0;
    wr_chk_en_c   = 1'b0;
`ifdef SEQ_LUT_VERIFY_EN
    base_d        = base_q;
    count_d       = count_q;
`endif

    if (abort_c && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      // Abort drops the strobe and ready at once; entries already written stay.
      state_d       = ST_ERR;
      load_error_d  = 1'b1;
      config_done_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // An abort in the same cycle suppresses the start.
          if (load_start_i && !abort_i) begin
            if (seq_busy_i) begin
              state_d      = ST_ERR;
              load_error_d = 1'b1;
            end else begin
              chk_clr_c     = 1'b1;
              config_done_d = 1'b0;
              load_error_d  = 1'b0;
              entries_d     = '0;
              ptr_d         = base_addr_i;
              left_d        = entry_count_i;
`ifdef SEQ_LUT_VERIFY_EN
              base_d        = base_addr_i;
              count_d       = entry_count_i;
`endif
              if (entry_count_i == '0) begin
                state_d       = ST_DONE;
                config_done_d = 1'b1;
              end else begin
                state_d   = ST_WRITE;
                s_ready_d = 1'b1;
              end
            end
          end
        end

        ST_WRITE: begin
          if (hs_c) begin
            lut_wen_d   = 1'b1;
            lut_addr_d  = ptr_q;
            lut_wdata_d = s_data_i;
            ptr_d       = ptr_q + 1'b1;
            left_d      = left_q - 1'b1;
            entries_d   = entries_q + 1'b1;
            wr_chk_en_c = 1'b1;
            s_ready_d   = (left_q != CW'(1));
          end else if (left_q == '0) begin
            // Last write is on the LUT port this cycle.
`ifdef SEQ_LUT_VERIFY_EN
            state_d    = ST_RD_ADDR;
            lut_addr_d = base_q;
            left_d     = count_q;
`else
            state_d       = ST_DONE;
            config_done_d = 1'b1;
`endif
          end else begin
            s_ready_d = 1'b1;
          end
        end

`ifdef SEQ_LUT_VERIFY_EN
        ST_RD_ADDR: begin
          if (left_q == CW'(1)) begin
            state_d = ST_RD_CMP;
          end else begin
            lut_addr_d = lut_addr_q + 1'b1;
            left_d     = left_q - 1'b1;
          end
        end

        ST_RD_CMP: begin
          if (rd_chk_nxt_c == wr_chk) begin
            state_d       = ST_DONE;
            config_done_d = 1'b1;
          end else begin
            state_d       = ST_ERR;
            load_error_d  = 1'b1;
            config_done_d = 1'b0;
          end
        end
`endif

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
  end

  assign s_ready_o         = s_ready_q;
  assign lut_addr_o        = lut_addr_q;
  assign lut_wen_o         = lut_wen_q;
  assign lut_write_data_o  = lut_wdata_q;
  assign config_done_o     = config_done_q;
  assign busy_o            = busy_q;
  assign load_error_o      = load_error_q;
  assign entries_written_o = entries_q;

endmodule

// File: tb/tb_seq_lut_loader.sv
// Self-checking bench for seq_lut_loader: drives entry bursts, keeps a
// scoreboard of expected LUT writes and models the LUT memory.
module tb_seq_lut_loader;
  import seq_lut_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
`ifdef SEQ_LUT_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk_20mhz = 1'b0;
  logic          rst_n_20mhz;
  logic          load_start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   entry_count_i;
  logic          abort_i;
  logic          seq_busy_i;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [AW-1:0] lut_addr_o;
  logic          lut_wen_o;
  logic [DW-1:0] lut_write_data_o;
  logic [DW-1:0] lut_read_data_i;
  logic          config_done_o;
  logic          busy_o;
  logic          load_error_o;
  logic [AW:0]   entries_written_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc = 0;
  wr_t exp_q[$];

  logic [DW-1:0] lut_mem [LUT_DEPTH];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always #25 clk_20mhz = ~clk_20mhz;

  seq_lut_loader #(.LUT_AW(AW), .LUT_DW(DW)) dut (
    .clk_20mhz         (clk_20mhz),
    .rst_n_20mhz       (rst_n_20mhz),
    .load_start_i      (load_start_i),
    .base_addr_i       (base_addr_i),
    .entry_count_i     (entry_count_i),
    .abort_i           (abort_i),
    .seq_busy_i        (seq_busy_i),
    .s_data_i          (s_data_i),
    .s_valid_i         (s_valid_i),
    .s_ready_o         (s_ready_o),
    .lut_addr_o        (lut_addr_o),
    .lut_wen_o         (lut_wen_o),
    .lut_write_data_o  (lut_write_data_o),
    .lut_read_data_i   (lut_read_data_i),
    .config_done_o     (config_done_o),
    .busy_o            (busy_o),
    .load_error_o      (load_error_o),
    .entries_written_o (entries_written_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_20mhz);
  endtask

  // LUT model: synchronous write, read data one cycle after the address.
  always @(posedge clk_20mhz) begin
    cyc <= cyc + 1;
    if (lut_wen_o)
      lut_mem[lut_addr_o] <= (corrupt_en && lut_addr_o == corrupt_addr) ?
                             ~lut_write_data_o : lut_write_data_o;
    lut_read_data_i <= lut_mem[lut_addr_o];
  end

  // Scoreboard: every write on the LUT port must match the oldest expected one.
  always @(negedge clk_20mhz) begin
    if (rst_n_20mhz && lut_wen_o) begin
      check("sb_expected_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_addr", 64'(lut_addr_o), 64'(e.addr));
        check("sb_data", 64'(lut_write_data_o), 64'(e.data));
      end
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
  end

  // Start a load and stream entries d0, d0+1, ...; optionally abort after
  // abort_after handshakes.
  task automatic run_load(input logic [AW-1:0] base, input int count,
                          input logic [DW-1:0] d0, input bit toggle,
                          input int abort_after);
    logic [AW-1:0] ptr;
    int sent;
    int guard;
    bit phase;
    ptr = base;
    sent = 0;
    guard = 0;
    phase = 1'b1;
    first_wr_cyc = -1;
    load_start_i = 1'b1;
    base_addr_i = base;
    entry_count_i = (AW+1)'(count);
    tick();
    load_start_i = 1'b0;
    if (count > 0) check("ready_after_start", 64'(s_ready_o), 64'(1));
    while (sent < count && guard < 200) begin
      if (sent == abort_after) begin
        s_valid_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        break;
      end
      s_valid_i = toggle ? phase : 1'b1;
      phase = ~phase;
      s_data_i = d0 + DW'(sent);
      if (s_valid_i && s_ready_o) begin
        exp_q.push_back(wr_t'({ptr, s_data_i}));
        ptr = ptr + 1'b1;
        sent++;
      end
      tick();
      guard++;
    end
    s_valid_i = 1'b0;
    if (guard >= 200) check("load_timeout", 64'(sent), 64'(count));
    if (abort_after < 0 && count > 0) check("ready_drop", 64'(s_ready_o), 64'(0));
  endtask

  // Wait for config_done_o and check its cycle relative to the last write.
  task automatic wait_done(input string tag, input int count);
    int n;
    int lat;
    n = 0;
    lat = VFY ? count + 2 : 1;
    while (config_done_o !== 1'b1 && load_error_o !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(config_done_o), 64'(1));
    check({tag, "_latency"}, 64'(cyc), 64'(last_wr_cyc + lat));
    check({tag, "_entries"}, 64'(entries_written_o), 64'(count));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
  endtask

  initial begin
    int w0;
    int n;
    rst_n_20mhz = 1'b0;
    load_start_i = 1'b0;
    base_addr_i = '0;
    entry_count_i = '0;
    abort_i = 1'b0;
    seq_busy_i = 1'b0;
    s_data_i = '0;
    s_valid_i = 1'b0;
    repeat (3) tick();
    check("rst_ready", 64'(s_ready_o), 64'(0));
    check("rst_wen", 64'(lut_wen_o), 64'(0));
    check("rst_addr", 64'(lut_addr_o), 64'(0));
    check("rst_done", 64'(config_done_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_err", 64'(load_error_o), 64'(0));
    check("rst_entries", 64'(entries_written_o), 64'(0));
    rst_n_20mhz = 1'b1;
    repeat (2) tick();

    // Basic load.
    w0 = wr_cnt;
    run_load(8'h10, 4, 32'hA0, 1'b0, -1);
    wait_done("basic", 4);
    check("basic_writes", 64'(wr_cnt - w0), 64'(4));
    check("basic_span", 64'(last_wr_cyc - first_wr_cyc), 64'(3));
    repeat (2) tick();

    // Address wrap-around.
    w0 = wr_cnt;
    run_load(8'hFE, 4, 32'hB0, 1'b0, -1);
    wait_done("wrap", 4);
    check("wrap_writes", 64'(wr_cnt - w0), 64'(4));

    // Backpressure: valid every other cycle.
    w0 = wr_cnt;
    run_load(8'h40, 5, 32'h5000, 1'b1, -1);
    wait_done("bp", 5);
    check("bp_writes", 64'(wr_cnt - w0), 64'(5));

`ifdef SEQ_LUT_VERIFY_EN
    // Readback mismatch: the LUT model corrupts the third entry.
    corrupt_en = 1'b1;
    corrupt_addr = 8'h62;
    run_load(8'h60, 4, 32'hD0, 1'b0, -1);
    n = 0;
    while (load_error_o !== 1'b1 && config_done_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("vfy_error", 64'(load_error_o), 64'(1));
    check("vfy_done", 64'(config_done_o), 64'(0));
    check("vfy_busy", 64'(busy_o), 64'(1));
    corrupt_en = 1'b0;
`endif

    // Abort after two writes.
    w0 = wr_cnt;
    run_load(8'h80, 6, 32'hC0, 1'b0, 2);
    check("abort_err", 64'(load_error_o), 64'(1));
    check("abort_ready", 64'(s_ready_o), 64'(0));
    check("abort_busy", 64'(busy_o), 64'(1));
    check("abort_done", 64'(config_done_o), 64'(0));
    repeat (5) tick();
    check("abort_writes", 64'(wr_cnt - w0), 64'(2));
    check("abort_entries", 64'(entries_written_o), 64'(2));

    // Start while the sequencer is busy is rejected.
    seq_busy_i = 1'b1;
    load_start_i = 1'b1;
    base_addr_i = 8'h00;
    entry_count_i = 9'd3;
    tick();
    load_start_i = 1'b0;
    seq_busy_i = 1'b0;
    check("busy_start_err", 64'(load_error_o), 64'(1));
    check("busy_start_done", 64'(config_done_o), 64'(0));
    check("busy_start_ready", 64'(s_ready_o), 64'(0));
    repeat (2) tick();

    // Zero-count load leaves ERR and completes one cycle after start.
    w0 = wr_cnt;
    load_start_i = 1'b1;
    base_addr_i = 8'h33;
    entry_count_i = '0;
    tick();
    load_start_i = 1'b0;
    check("zero_done", 64'(config_done_o), 64'(1));
    check("zero_err_clr", 64'(load_error_o), 64'(0));
    check("zero_entries", 64'(entries_written_o), 64'(0));
    check("zero_ready", 64'(s_ready_o), 64'(0));
    repeat (3) tick();
    check("zero_writes", 64'(wr_cnt - w0), 64'(0));

    // Normal load after recovery.
    run_load(8'h20, 3, 32'hE0, 1'b0, -1);
    wait_done("recover", 3);
    repeat (3) tick();
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
